// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one 64-bit Y86 ALU (add/sub/and/xor) between two
// valid/ready requesters. It uses round-robin or fixed-priority arbitration.
// It has a three-state IDLE -> EXEC -> RESP sequencer with a registered
// response and the architectural condition codes ZF/SF/OF.
// Optional build macro: ALU_ARB_STATS_EN adds saturating grant/stall counters.
module alu_share_arbiter #(
  parameter int DATA_W     = 64,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_fun,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_setcc,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_fun,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_setcc,
  output logic [1:0]        alu_control,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry_out,
  input  logic              alu_overflow_check,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_grant0,
  output logic [CNT_W-1:0]  stat_grant1,
  output logic [CNT_W-1:0]  stat_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          fun_q, fun_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                setcc_q, setcc_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                carry_q, carry_d;
  logic                zf_q, zf_d;
  logic                sf_q, sf_d;
  logic                of_q, of_d;
  logic                grant0_s, grant1_s;
  logic                hs0_s, hs1_s;

  // Pick the winner among the requesting ports; on a tie use priority or
  // hand the grant to the port that did not win last time.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRIO || last_grant_q) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Ready is only offered in IDLE and is held low while reset is asserted so
  // that every output reads 0 during reset.
  assign req0_ready = (state_q == IDLE) && grant0_s && !rst;
  assign req1_ready = (state_q == IDLE) && grant1_s && !rst;
  assign hs0_s      = req0_ready;
  assign hs1_s      = req1_ready;

  // Next-state, operand latching, result capture and condition-code update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    fun_d        = fun_q;
    a_d          = a_q;
    b_d          = b_q;
    setcc_d      = setcc_q;
    id_d         = id_q;
    result_d     = result_q;
    carry_d      = carry_q;
    zf_d         = zf_q;
    sf_d         = sf_q;
    of_d         = of_q;
    case (state_q)
      IDLE: begin
        if (hs0_s) begin
          fun_d        = req0_fun;
          a_d          = req0_a;
          b_d          = req0_b;
          setcc_d      = req0_setcc;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (hs1_s) begin
          fun_d        = req1_fun;
          a_d          = req1_a;
          b_d          = req1_b;
          setcc_d      = req1_setcc;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = alu_out;
        carry_d  = alu_carry_out;
        if (setcc_q) begin
          zf_d = (alu_out == {DATA_W{1'b0}});
          sf_d = alu_out[DATA_W-1];
          of_d = alu_overflow_check;
        end else begin
          zf_d = zf_q;
          sf_d = sf_q;
          of_d = of_q;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      fun_q        <= 2'd0;
      a_q          <= {DATA_W{1'b0}};
      b_q          <= {DATA_W{1'b0}};
      setcc_q      <= 1'b0;
      id_q         <= 1'b0;
      result_q     <= {DATA_W{1'b0}};
      carry_q      <= 1'b0;
      zf_q         <= 1'b0;
      sf_q         <= 1'b0;
      of_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      fun_q        <= fun_d;
      a_q          <= a_d;
      b_q          <= b_d;
      setcc_q      <= setcc_d;
      id_q         <= id_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      zf_q         <= zf_d;
      sf_q         <= sf_d;
      of_q         <= of_d;
    end
  end

  assign alu_control = fun_q;
  assign alu_in1     = a_q;
  assign alu_in2     = b_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_result  = result_q;
  assign rsp_carry   = carry_q;
  assign cc_zf       = zf_q;
  assign cc_sf       = sf_q;
  assign cc_of       = of_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant0_cnt_q, grant0_cnt_d;
  logic [CNT_W-1:0] grant1_cnt_q, grant1_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_s;

  // Saturating increments for the grant and stall statistics.
  always_comb begin
    grant0_cnt_d = grant0_cnt_q;
    grant1_cnt_d = grant1_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    stall_s      = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);
    if (hs0_s && (grant0_cnt_q != {CNT_W{1'b1}})) begin
      grant0_cnt_d = grant0_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      grant0_cnt_d = grant0_cnt_q;
    end
    if (hs1_s && (grant1_cnt_q != {CNT_W{1'b1}})) begin
      grant1_cnt_d = grant1_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      grant1_cnt_d = grant1_cnt_q;
    end
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant0_cnt_q <= {CNT_W{1'b0}};
      grant1_cnt_q <= {CNT_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      grant0_cnt_q <= grant0_cnt_d;
      grant1_cnt_q <= grant1_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stat_grant0 = grant0_cnt_q;
  assign stat_grant1 = grant1_cnt_q;
  assign stat_stall  = stall_cnt_q;
`endif

endmodule
